// File: rtl/data_store_buffer_pkg.sv
// Shared constants for the posted-write store buffer: drain FSM encoding,
// word-offset bit position and default geometry.
package store_buffer_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Loads and stores match on word address; byte offset bits are ignored.
  localparam int WORD_LSB = 2;

  localparam logic [0:0] SB_IDLE = 1'b0;
  localparam logic [0:0] SB_REQ  = 1'b1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/data_store_buffer_if.sv
// Core-side store/load signals and memory-side drain handshake of the store buffer.
// slave = buffer view, master = core/memory/testbench view.
interface data_store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  logic              sb_empty;
  logic [CNT_W-1:0]  sb_count;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    output st_ready, ld_hit, ld_data, ld_stall,
           mem_req, mem_addr, mem_wdata, sb_empty, sb_count
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
    input  st_ready, ld_hit, ld_data, ld_stall,
           mem_req, mem_addr, mem_wdata, sb_empty, sb_count
  );

endinterface

// File: rtl/data_store_buffer_addr_match.sv
// DEPTH-way word-address comparator over the valid buffer entries; when several
// entries match, the youngest (closest to wr_ptr-1) supplies hit_data_o.
module sb_addr_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = cnt_width(DEPTH),
  parameter int WORD_W = ADDR_W - WORD_LSB
) (
  input  logic [WORD_W-1:0] entry_word_i [DEPTH],
  input  logic [DATA_W-1:0] entry_data_i [DEPTH],
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic [WORD_W-1:0] ld_word_i,
  output logic              any_hit_o,
  output logic [DATA_W-1:0] hit_data_o
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest valid age to youngest so the youngest match wins.
  always_comb begin
    any_hit_o  = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr_i - PTR_W'(k + 1);
      if ((CNT_W'(k) < count_i) && (entry_word_i[idx] == ld_word_i)) begin
        any_hit_o  = 1'b1;
        hit_data_o = entry_data_i[idx];
      end
    end
  end

endmodule

// File: rtl/data_store_buffer.sv
// Posted-write store buffer: FIFO of core stores drained to data memory by a
// req/ack FSM, with load hazard check. Define STORE_FWD_EN to forward load data.
//
// state   | meaning
// SB_IDLE | no write request outstanding
// SB_REQ  | head entry presented on mem_*, waiting for mem_ack
module data_store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic                 clk,
  input logic                 rst_n,
  data_store_buffer_if.slave  bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int WORD_W = ADDR_W - WORD_LSB;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [WORD_W-1:0] entry_word [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:0]        state_q, state_d;

  logic              st_ready;
  logic              push;
  logic              pop;
  logic              mem_req;
  logic              any_hit;
  logic [DATA_W-1:0] hit_data;

  // A full buffer never accepts a store, even in a cycle that pops.
  assign st_ready = (count_q != CNT_W'(DEPTH));
  assign mem_req  = (state_q == SB_REQ);
  assign push     = bus.st_valid && st_ready;
  assign pop      = mem_req && bus.mem_ack;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: if (count_q != '0) state_d = SB_REQ;
      SB_REQ:  if (pop && (count_d == '0)) state_d = SB_IDLE;
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= SB_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr_q] <= bus.st_addr;
      data_q[wr_ptr_q] <= bus.st_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_word[i] = addr_q[i][ADDR_W-1:WORD_LSB];
    end
  end

  sb_addr_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match (
    .entry_word_i (entry_word),
    .entry_data_i (data_q),
    .wr_ptr_i     (wr_ptr_q),
    .count_i      (count_q),
    .ld_word_i    (bus.ld_addr[ADDR_W-1:WORD_LSB]),
    .any_hit_o    (any_hit),
    .hit_data_o   (hit_data)
  );

  logic unused_ld_lsb;
  assign unused_ld_lsb = ^bus.ld_addr[WORD_LSB-1:0];

`ifdef STORE_FWD_EN
  assign bus.ld_hit   = bus.ld_valid && any_hit;
  assign bus.ld_data  = (bus.ld_valid && any_hit) ? hit_data : '0;
  assign bus.ld_stall = 1'b0;
`else
  logic unused_hit_data;
  assign unused_hit_data = ^hit_data;
  assign bus.ld_hit   = 1'b0;
  assign bus.ld_data  = '0;
  assign bus.ld_stall = bus.ld_valid && any_hit;
`endif

  assign bus.st_ready  = st_ready;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_req ? addr_q[rd_ptr_q] : '0;
  assign bus.mem_wdata = mem_req ? data_q[rd_ptr_q] : '0;
  assign bus.sb_empty  = (count_q == '0);
  assign bus.sb_count  = count_q;

endmodule

// File: tb/tb_data_store_buffer.sv
// Self-checking bench for data_store_buffer: directed tables, hand sequences
// for reset/forwarding corners, and randomized traffic against a queue model.
module tb_data_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  data_store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  // Reference: pending stores in age order, plus whether a write request is outstanding.
  ent_t mq[$];
  bit   m_req;

  typedef struct {
    logic          sv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          ack;
    int            exp_count;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    logic          exp_ready;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lv, input logic [AW-1:0] la, input logic ack);
    bus.st_valid = sv;
    bus.st_addr  = sa;
    bus.st_data  = sd;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    bus.mem_ack  = ack;
  endtask

  task automatic model_reset();
    mq.delete();
    m_req = 1'b0;
  endtask

  task automatic model_check();
    bit            found = 1'b0;
    logic [DW-1:0] fd    = '0;
    ent_t          head  = '{default: '0};
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].addr[AW-1:2] == bus.ld_addr[AW-1:2]) begin
        found = 1'b1;
        fd    = mq[i].data;
      end
    end
    if (m_req && mq.size() != 0) head = mq[0];
    chk("st_ready",  bus.st_ready,  mq.size() != DEPTH);
    chk("mem_req",   bus.mem_req,   m_req);
    chk("mem_addr",  bus.mem_addr,  head.addr);
    chk("mem_wdata", bus.mem_wdata, head.data);
    chk("sb_empty",  bus.sb_empty,  mq.size() == 0);
    chk("sb_count",  bus.sb_count,  mq.size());
    chk("ld_hit",    bus.ld_hit,    FWD && bus.ld_valid && found);
    chk("ld_data",   bus.ld_data,   (FWD && bus.ld_valid && found) ? fd : '0);
    chk("ld_stall",  bus.ld_stall,  !FWD && bus.ld_valid && found);
  endtask

  task automatic model_tick();
    int old_n = mq.size();
    bit pop   = m_req && bus.mem_ack;
    bit push  = bus.st_valid && (old_n != DEPTH);
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{bus.st_addr, bus.st_data});
    if (m_req) m_req = pop ? (mq.size() != 0) : 1'b1;
    else       m_req = (old_n != 0);
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] ta(input int i);
    return 32'h100 + 32'(4 * i);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    settle();
    rst_n = 1'b1;
    @(negedge clk);

    // Ordered drain with ack tied high, then fill/overflow/wrap with held acks.
    tbl.push_back('{1, 32'h10, 32'h11, 1, 0, 0, 32'h0,  1});
    tbl.push_back('{1, 32'h14, 32'h22, 1, 1, 0, 32'h0,  1});
    tbl.push_back('{1, 32'h18, 32'h33, 1, 2, 1, 32'h10, 1});
    tbl.push_back('{0, 32'h0,  32'h0,  1, 2, 1, 32'h14, 1});
    tbl.push_back('{0, 32'h0,  32'h0,  1, 1, 1, 32'h18, 1});
    tbl.push_back('{0, 32'h0,  32'h0,  1, 0, 0, 32'h0,  1});
    tbl.push_back('{1, ta(0), 32'hD0, 0, 0, 0, 32'h0,  1});
    tbl.push_back('{1, ta(1), 32'hD1, 0, 1, 0, 32'h0,  1});
    tbl.push_back('{1, ta(2), 32'hD2, 0, 2, 1, ta(0),  1});
    tbl.push_back('{1, ta(3), 32'hD3, 0, 3, 1, ta(0),  1});
    tbl.push_back('{1, ta(4), 32'hD4, 0, 4, 1, ta(0),  0});
    tbl.push_back('{1, ta(4), 32'hD4, 1, 4, 1, ta(0),  0});
    tbl.push_back('{1, ta(4), 32'hD4, 0, 3, 1, ta(1),  1});
    tbl.push_back('{0, 32'h0, 32'h0,  0, 4, 1, ta(1),  0});
    tbl.push_back('{1, ta(5), 32'hD5, 1, 4, 1, ta(1),  0});
    tbl.push_back('{1, ta(5), 32'hD5, 1, 3, 1, ta(2),  1});
    tbl.push_back('{1, ta(6), 32'hD6, 1, 3, 1, ta(3),  1});
    tbl.push_back('{0, 32'h0, 32'h0,  1, 3, 1, ta(4),  1});
    tbl.push_back('{0, 32'h0, 32'h0,  1, 2, 1, ta(5),  1});
    tbl.push_back('{0, 32'h0, 32'h0,  1, 1, 1, ta(6),  1});
    tbl.push_back('{0, 32'h0, 32'h0,  0, 0, 0, 32'h0,  1});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sv, tbl[i].sa, tbl[i].sd, 0, 0, tbl[i].ack);
      settle();
      chk($sformatf("tbl%0d_count", i), bus.sb_count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_req",   i), bus.mem_req,  tbl[i].exp_req);
      chk($sformatf("tbl%0d_addr",  i), bus.mem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_ready", i), bus.st_ready, tbl[i].exp_ready);
      tick();
    end

    // Asynchronous reset in the middle of a drain with three entries pending.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + 32'(4 * i), 32'hE0 + 32'(i), 0, 0, 0);
      settle();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("pre_rst_count", bus.sb_count, 3);
    chk("pre_rst_req", bus.mem_req, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    settle();
    chk("rst_req", bus.mem_req, 0);
    chk("rst_empty", bus.sb_empty, 1);
    chk("rst_count", bus.sb_count, 0);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("post_rst_no_write", bus.mem_req, 0);
      tick();
    end

    // Two stores to the same word, then load hazard / forwarding checks.
    drive(1, 32'h20, 32'hAAAA, 0, 0, 0); settle(); tick();
    drive(1, 32'h20, 32'hBBBB, 0, 0, 0); settle(); tick();
    drive(0, 0, 0, 1, 32'h22, 0);
    settle();
    chk("fwd_hit",   bus.ld_hit,   FWD);
    chk("fwd_data",  bus.ld_data,  FWD ? 32'hBBBB : 32'h0);
    chk("fwd_stall", bus.ld_stall, !FWD);
    tick();
    drive(0, 0, 0, 1, 32'h24, 0);
    settle();
    chk("miss_stall", bus.ld_stall, 0);
    chk("miss_hit",   bus.ld_hit,   0);
    tick();
    drive(0, 0, 0, 1, 32'h22, 1);
    n = 0;
    while (n < 10) begin
      settle();
      if (!bus.ld_stall) break;
      tick();
      n++;
    end
    chk("stall_timeout", n < 10, 1);
    chk("stall_release_count", bus.sb_count, FWD ? 2 : 0);
    tick();
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) begin settle(); tick(); end

    // Randomized traffic over a small address window to provoke matches.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1) == 1,
            32'h40 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)),
            $urandom,
            $urandom_range(0, 1) == 1,
            32'h40 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0);
      settle();
      tick();
    end
    drive(0, 0, 0, 0, 0, 1);
    repeat (DEPTH + 2) begin settle(); tick(); end
    settle();
    chk("final_empty", bus.sb_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
